// File: rtl/hc_rd_arbiter.sv
// Round-robin arbiter sharing the CCI-P c0 read channel between NUM_REQ readers.
// Define HC_RD_ARB_STATS_EN to add stall and per-requester grant counters.
module hc_rd_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 64,
    parameter int ADDR_W          = 42,
    parameter int MDATA_W         = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      c0_tx_valid,
    output logic [ADDR_W-1:0]         c0_tx_addr,
    output logic [MDATA_W-1:0]        c0_tx_mdata,
    input  logic                      c0_tx_alm_full,
    input  logic                      c0_rx_valid,
    input  logic [MDATA_W-1:0]        c0_rx_mdata,
    input  logic [511:0]              c0_rx_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [511:0]              rsp_data,
    output logic [7:0]                outstanding,
    output logic                      idle,
    output logic                      err_tag
`ifdef HC_RD_ARB_STATS_EN
    ,
    output logic [31:0]               stall_cycles,
    output logic [NUM_REQ*32-1:0]     grant_cnt
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W:0] NR = (ID_W+1)'(NUM_REQ);
    localparam logic [8:0] MAX_OUT = 9'(MAX_OUTSTANDING);

    logic [ID_W-1:0]    r_rr;
    logic               r_tx_valid;
    logic [ADDR_W-1:0]  r_tx_addr;
    logic [MDATA_W-1:0] r_tx_mdata;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [511:0]       r_rsp_data;
    logic [7:0]         r_outstanding;
    logic               r_err;

    logic [8:0]         w_inflight;
    logic               w_can;
    logic               w_found;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_gnt_id;
    logic [ADDR_W-1:0]  w_gnt_addr;
    logic [ID_W:0]      w_sum;
    logic [ID_W-1:0]    w_rr_nxt;
    logic [ID_W-1:0]    w_tag_id;
    logic               w_tag_hi_zero;
    logic               w_tag_ok;
    logic               w_rsp_hit;
    logic               w_underflow;
    logic [7:0]         w_out_nxt;

    // Slots already registered toward c0Tx count against the limit too.
    assign w_inflight = {1'b0, r_outstanding} + {8'd0, r_tx_valid};
    assign w_can = reset_n && !c0_tx_alm_full && (w_inflight < MAX_OUT);

    always_comb begin
        w_found    = 1'b0;
        w_grant    = '0;
        w_gnt_id   = '0;
        w_gnt_addr = '0;
        w_sum      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_rr} + (ID_W+1)'(i);
            if (w_sum >= NR) begin
                w_sum = w_sum - NR;
            end
            if (w_can && !w_found && req_valid[w_sum[ID_W-1:0]]) begin
                w_found    = 1'b1;
                w_gnt_id   = w_sum[ID_W-1:0];
                w_grant    = NUM_REQ'(1) << w_sum[ID_W-1:0];
                w_gnt_addr = req_addr[w_sum[ID_W-1:0]*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_rr_nxt = ({1'b0, w_gnt_id} == NR - 1'b1) ? '0 : w_gnt_id + 1'b1;

    assign w_tag_id      = c0_rx_mdata[ID_W-1:0];
    assign w_tag_hi_zero = ~|c0_rx_mdata[MDATA_W-1:ID_W];
    assign w_tag_ok      = w_tag_hi_zero && ({1'b0, w_tag_id} < NR);
    assign w_rsp_hit     = c0_rx_valid && w_tag_ok;

    always_comb begin
        w_out_nxt   = r_outstanding;
        w_underflow = 1'b0;
        if (r_tx_valid && !w_rsp_hit) begin
            w_out_nxt = r_outstanding + 8'd1;
        end else if (!r_tx_valid && w_rsp_hit) begin
            if (r_outstanding == 8'd0) begin
                w_underflow = 1'b1;
            end else begin
                w_out_nxt = r_outstanding - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr          <= '0;
            r_tx_valid    <= 1'b0;
            r_tx_addr     <= '0;
            r_tx_mdata    <= '0;
            r_rsp_valid   <= '0;
            r_rsp_data    <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            r_tx_valid    <= w_found;
            r_outstanding <= w_out_nxt;
            if (w_found) begin
                r_tx_addr  <= w_gnt_addr;
                r_tx_mdata <= MDATA_W'(w_gnt_id);
                r_rr       <= w_rr_nxt;
            end
            r_rsp_valid <= w_rsp_hit ? (NUM_REQ'(1) << w_tag_id) : '0;
            if (w_rsp_hit) begin
                r_rsp_data <= c0_rx_data;
            end
            if ((c0_rx_valid && !w_tag_ok) || w_underflow) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef HC_RD_ARB_STATS_EN
    logic [31:0] r_stall;
    logic [31:0] r_gcnt [NUM_REQ];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_gcnt[i] <= '0;
            end
        end else begin
            if ((|req_valid) && !w_can && (r_stall != '1)) begin
                r_stall <= r_stall + 32'd1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i] && (r_gcnt[i] != '1)) begin
                    r_gcnt[i] <= r_gcnt[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*32 +: 32] = r_gcnt[i];
        end
    end

    assign stall_cycles = r_stall;
`endif

    assign req_ready   = w_grant;
    assign c0_tx_valid = r_tx_valid;
    assign c0_tx_addr  = r_tx_addr;
    assign c0_tx_mdata = r_tx_mdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign outstanding = r_outstanding;
    assign err_tag     = r_err;
    assign idle = !reset_n ||
                  ((r_outstanding == 8'd0) && !(|req_valid) && !r_tx_valid);

endmodule
